// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
//   state_t : controller states (idle / comparing)
//   dec_t   : sticky per-comparison decision (none yet / A greater / A less)
package seq_cmp_pkg;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StCompare = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DecNone = 2'b00,
    DecGt   = 2'b01,
    DecLt   = 2'b10
  } dec_t;

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
// Ports:
//   a, b : DIGIT-bit digits to compare
//   gt   : a > b
//   lt   : a < b
module cmp_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands most-significant
// digit first, DIGIT bits per clock, with a start/busy/done handshake. Results are
// registered and held until the next comparison completes.
//
// Optional build macro SEQ_CMP_EARLY_EXIT_EN: finish on the first differing digit
// instead of always spending N cycles (constant-time when undefined).
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start             : request, sampled only while idle
//   signed_mode       : 1 = two's-complement compare, sampled with start
//   a, b              : operands, sampled with start
//   busy              : comparison in progress
//   done              : one-cycle pulse when results update
//   a_bigger, b_bigger, equals : A > B, A < B, A == B
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_bigger,
  output logic             b_bigger,
  output logic             equals
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_check
    $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dec_t               dec_q, dec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               a_bigger_q, a_bigger_d;
  logic               b_bigger_q, b_bigger_d;
  logic               equals_q, equals_d;

  logic               dig_gt, dig_lt;
  dec_t               dec_next;
  logic               finish;

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_cmp_digit (
    .a  (a_sh_q[WIDTH-1 -: DIGIT]),
    .b  (b_sh_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;
    dec_d      = dec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    a_bigger_d = a_bigger_q;
    b_bigger_d = b_bigger_q;
    equals_d   = equals_q;

    // The first differing digit decides; later digits cannot override it.
    dec_next = dec_q;
    if (dec_q == DecNone) begin
      if (dig_gt) begin
        dec_next = DecGt;
      end else if (dig_lt) begin
        dec_next = DecLt;
      end
    end

`ifdef SEQ_CMP_EARLY_EXIT_EN
    finish = (cnt_q == '0) || (dec_next != DecNone);
`else
    finish = (cnt_q == '0);
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Flipping the sign bit maps two's complement onto offset binary, so the
          // unsigned digit compare orders signed values correctly.
          a_sh_d  = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
          b_sh_d  = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
          cnt_d   = CNT_W'(N - 1);
          dec_d   = DecNone;
          busy_d  = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        a_sh_d = a_sh_q << DIGIT;
        b_sh_d = b_sh_q << DIGIT;
        cnt_d  = cnt_q - CNT_W'(1);
        dec_d  = dec_next;
        if (finish) begin
          a_bigger_d = (dec_next == DecGt);
          b_bigger_d = (dec_next == DecLt);
          equals_d   = (dec_next == DecNone);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cnt_q      <= '0;
      dec_q      <= DecNone;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_bigger_q <= 1'b0;
      b_bigger_q <= 1'b0;
      equals_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a_bigger_q <= a_bigger_d;
      b_bigger_q <= b_bigger_d;
      equals_q   <= equals_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign a_bigger = a_bigger_q;
  assign b_bigger = b_bigger_q;
  assign equals   = equals_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: directed 8-bit/2-bit-digit
// scenarios through a result scoreboard, then exhaustive 4-bit runs with DIGIT=1
// and DIGIT=4 against a behavioural compare model.
module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic       rst;
  logic       start, sm;
  logic [7:0] a, b;
  logic       busy, done, ab, bb, eq;

  logic       s4, sm4;
  logic [3:0] a4, b4;
  logic       busy1, done1, ab1, bb1, eq1;
  logic       busy4, done4, ab4, bb4, eq4;

  typedef struct packed {
    logic        ab;
    logic        bb;
    logic        eq;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy), .done(done), .a_bigger(ab), .b_bigger(bb), .equals(eq)
  );

  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy1), .done(done1), .a_bigger(ab1), .b_bigger(bb1), .equals(eq1)
  );

  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .a_bigger(ab4), .b_bigger(bb4), .equals(eq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural result: signed operands are sign-extended into int first.
  task automatic model_res(input int unsigned av, input int unsigned bv, input int w,
                           input bit smv, output logic e_ab, output logic e_bb,
                           output logic e_eq);
    int sa, sb;
    sa = int'(av);
    sb = int'(bv);
    if (smv && ((av >> (w - 1)) & 1) == 1) sa = sa - (1 << w);
    if (smv && ((bv >> (w - 1)) & 1) == 1) sb = sb - (1 << w);
    e_ab = (sa > sb);
    e_bb = (sa < sb);
    e_eq = (sa == sb);
  endtask

  function automatic int unsigned model_lat(input int unsigned av, input int unsigned bv,
                                            input int w, input int d);
    int n;
    int unsigned mask;
    n    = w / d;
    mask = (32'd1 << d) - 1;
    if (!EARLY) return n;
    for (int i = 0; i < n; i++) begin
      if (((av >> (w - (i + 1) * d)) & mask) != ((bv >> (w - (i + 1) * d)) & mask))
        return i + 1;
    end
    return n;
  endfunction

  task automatic push_exp(input logic [7:0] av, input logic [7:0] bv, input bit smv,
                          input int unsigned done_cyc);
    exp_t e;
    model_res(av, bv, 8, smv, e.ab, e.bb, e.eq);
    e.cyc = done_cyc;
    q.push_back(e);
  endtask

  // Drive one request; edge k is the posedge following this negedge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input bit smv,
                          input bit push);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sm    = smv;
    if (push) push_exp(av, bv, smv, cyc + 1 + model_lat(av, bv, 8, 2));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (seen) begin
        chk({tag, "_latency"}, cyc, e.cyc);
        chk({tag, "_a_bigger"}, 32'(ab), 32'(e.ab));
        chk({tag, "_b_bigger"}, 32'(bb), 32'(e.bb));
        chk({tag, "_equals"}, 32'(eq), 32'(e.eq));
        chk({tag, "_onehot"}, 32'(ab) + 32'(bb) + 32'(eq), 32'd1);
      end
    end
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input bit smv);
    logic        e_ab, e_bb, e_eq;
    int unsigned base, l1;
    bit          g1, g4;
    string       id;
    g1 = 1'b0;
    g4 = 1'b0;
    id = $sformatf("a=%0h b=%0h sm=%0d", av, bv, smv);
    model_res(av, bv, 4, smv, e_ab, e_bb, e_eq);
    l1 = model_lat(av, bv, 4, 1);
    @(negedge clk);
    s4   = 1'b1;
    a4   = av;
    b4   = bv;
    sm4  = smv;
    base = cyc + 1;
    @(posedge clk);
    #1 s4 = 1'b0;
    for (int i = 0; i < 8 && !(g1 && g4); i++) begin
      @(negedge clk);
      if (done1 && !g1) begin
        g1 = 1'b1;
        chk({"d1_latency ", id}, cyc, base + l1);
        chk({"d1_a_bigger ", id}, 32'(ab1), 32'(e_ab));
        chk({"d1_b_bigger ", id}, 32'(bb1), 32'(e_bb));
        chk({"d1_equals ", id}, 32'(eq1), 32'(e_eq));
        chk({"d1_onehot ", id}, 32'(ab1) + 32'(bb1) + 32'(eq1), 32'd1);
      end
      if (done4 && !g4) begin
        g4 = 1'b1;
        chk({"d4_latency ", id}, cyc, base + 1);
        chk({"d4_a_bigger ", id}, 32'(ab4), 32'(e_ab));
        chk({"d4_b_bigger ", id}, 32'(bb4), 32'(e_bb));
        chk({"d4_equals ", id}, 32'(eq4), 32'(e_eq));
        chk({"d4_onehot ", id}, 32'(ab4) + 32'(bb4) + 32'(eq4), 32'd1);
      end
    end
    chk({"d1_done_seen ", id}, 32'(g1), 32'd1);
    chk({"d4_done_seen ", id}, 32'(g4), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sm    = 1'b0;
    a     = '0;
    b     = '0;
    s4    = 1'b0;
    sm4   = 1'b0;
    a4    = '0;
    b4    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_a_bigger", 32'(ab), 32'd0);
    chk("rst_b_bigger", 32'(bb), 32'd0);
    chk("rst_equals", 32'(eq), 32'd0);
    chk("rst_busy_d1", 32'(busy1), 32'd0);
    chk("rst_busy_d4", 32'(busy4), 32'd0);
    rst = 1'b0;

    // Directed compares
    start_op(8'hA5, 8'hA4, 1'b0, 1'b1);
    wait_done("a5_a4_u", 12);
    start_op(8'h40, 8'h3F, 1'b0, 1'b1);
    wait_done("40_3f_u", 12);
    start_op(8'h80, 8'h7F, 1'b1, 1'b1);
    wait_done("80_7f_s", 12);
    start_op(8'h80, 8'h7F, 1'b0, 1'b1);
    wait_done("80_7f_u", 12);
    start_op(8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_done("5a_5a_u", 12);
    start_op(8'h5A, 8'h5A, 1'b1, 1'b1);
    wait_done("5a_5a_s", 12);

    // Inputs and start toggled while busy must not disturb the captured operands
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    sm    = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignore_busy_high", 32'(busy), 32'd1);
    wait_done("ignore_while_busy", 12);

    // start held through done: second capture on the edge after done
    begin
      int unsigned d1;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      sm    = 1'b0;
      d1    = cyc + 1 + model_lat(8'h12, 8'h34, 8, 2);
      push_exp(8'h12, 8'h34, 1'b0, d1);
      @(posedge clk);
      #1;
      a  = 8'hC3;
      b  = 8'hC3;
      sm = 1'b1;
      push_exp(8'hC3, 8'hC3, 1'b1, d1 + 1 + model_lat(8'hC3, 8'hC3, 8, 2));
      wait_done("b2b_first", 12);
      chk("b2b_busy_in_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("b2b_second", 12);
    end

    // Asynchronous reset between edges mid-compare
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_a_bigger", 32'(ab), 32'd0);
    chk("arst_b_bigger", 32'(bb), 32'd0);
    chk("arst_equals", 32'(eq), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("arst_no_done_%0d", i), 32'(done), 32'd0);
    end
    chk("arst_results_held_zero", 32'(ab) + 32'(bb) + 32'(eq), 32'd0);
    start_op(8'hA5, 8'hA4, 1'b0, 1'b1);
    wait_done("after_reset", 12);

    // Exhaustive 4-bit, DIGIT=1 and DIGIT=4, both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          run4(4'(x), 4'(y), m[0]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
